// File: rtl/dmem_responder.sv
// Data-memory responder for an RV32I load/store port: one request at a time,
// programmable response latency, byte/half/word lane steering and fault flagging.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_mode,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {INIT, IDLE, BUSY, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        we_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [2:0]  mode_p0;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept, commit, retire, fault;
    logic [AW-1:0] widx;
    logic [31:0]   word_rd, load_data, wr_data;
    logic [3:0]    byte_en;

    // Range, alignment and mode legality of a latched request.
    function automatic logic access_fault(input logic we, input logic [31:0] addr,
                                          input logic [2:0] mode);
        logic [31:0] word_addr;
        logic        f;
        word_addr = {2'b00, addr[31:2]};
        f = (word_addr >= 32'(DEPTH_WORDS));
        case (mode)
            3'b000:  f = f;
            3'b001:  f = f | addr[0];
            3'b010:  f = f | (addr[1:0] != 2'b00);
            3'b100:  f = f | we;
            3'b101:  f = f | we | addr[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] mode);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = $signed(word[8*lane +: 8]);
        h = $signed(lane[1] ? word[31:16] : word[15:0]);
        case (mode)
            3'b000:  return 32'(b);
            3'b100:  return {24'b0, b};
            3'b001:  return 32'(h);
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] store_enables(input logic [1:0] lane, input logic [2:0] mode);
        case (mode[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [31:0] wdata, input logic [2:0] mode);
        case (mode[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    always_comb begin
        accept    = (state == IDLE) && req_valid;
        commit    = (state == BUSY) && (cnt == 4'd0);
        retire    = (state == RESP) && rsp_ready;
        fault     = access_fault(we_p0, addr_p0, mode_p0);
        widx      = addr_p0[AW+1:2];
        word_rd   = mem[widx];
        load_data = extend_load(word_rd, addr_p0[1:0], mode_p0);
        byte_en   = store_enables(addr_p0[1:0], mode_p0);
        wr_data   = store_data(wdata_p0, mode_p0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: state_nxt = IDLE;
            IDLE: if (req_valid)        state_nxt = BUSY;
            BUSY: if (cnt == 4'd0)      state_nxt = RESP;
            RESP: if (rsp_ready)        state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // Request latch, latency countdown, and response registers (commit edge).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 4'd0;
            we_p0     <= 1'b0;
            addr_p0   <= 32'd0;
            wdata_p0  <= 32'd0;
            mode_p0   <= 3'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_p0    <= req_we;
                addr_p0  <= req_addr;
                wdata_p0 <= req_wdata;
                mode_p0  <= req_mode;
                cnt      <= 4'(LATENCY - 1);
            end else if ((state == BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_err   <= fault;
                rsp_rdata <= (fault || we_p0) ? 32'd0 : load_data;
            end else if (retire) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

    // The array is deliberately left out of reset; a reset mid-request leaves it untouched.
    always_ff @(posedge clk) begin
        if (commit && we_p0 && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[widx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed reference memory.
module tb_dmem_responder;

    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [4*DEPTH_WORDS];

    dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-level memory model: access size from mode, little-endian gather, then extend.
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [2:0] mode, output logic [31:0] rd, output logic er);
        int size;
        logic [31:0] v;
        rd = 32'd0;
        er = 1'b0;
        case (mode)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0)                       er = 1'b1;
        else if (we && mode >= 3'd4)         er = 1'b1;
        else if ((addr % 32'(size)) != 0)    er = 1'b1;
        else if ((addr / 4) >= DEPTH_WORDS)  er = 1'b1;
        if (er) return;
        if (we) begin
            for (int k = 0; k < size; k++) begin
                v = wdata >> (8 * k);
                ref_mem[addr + 32'(k)] = v[7:0];
            end
        end else begin
            v = 32'd0;
            for (int k = 0; k < size; k++)
                v = v | (32'(ref_mem[addr + 32'(k)]) << (8 * k));
            if (mode < 3'd4 && size < 4 && v[8*size-1])
                v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
        end
    endfunction

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] mode, input int hold, input string tag,
                          output logic [31:0] rdata, output logic err);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        rdata = 32'd0;
        err   = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            check({tag, "_ready"}, 32'(req_ready), 32'd1);
            return;
        end
        model(we, addr, wdata, mode, exp_d, exp_e);
        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_mode  = mode;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_mode  = 3'($urandom);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rsp_valid && n < 20);
        check({tag, "_lat"}, 32'(n), 32'(LATENCY));
        if (!rsp_valid) return;
        rdata = rsp_rdata;
        err   = rsp_err;
        check({tag, "_data"}, rsp_rdata, exp_d);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h10;
            req_wdata = 32'd0;
            req_mode  = 3'b010;
            @(posedge clk); #1;
            check({tag, "_hold_vld"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_data"}, rsp_rdata, exp_d);
            check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_ret_vld"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ret_data"}, {rsp_rdata[31:1], rsp_err}, 32'd0);
        check({tag, "_ret_rdy"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] a;
        int          r;
        for (int i = 0; i < 4*DEPTH_WORDS; i++) ref_mem[i] = 8'h00;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_mode = 3'd0;
        rsp_ready = 1'b1;
        #3;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("init_ready", 32'(req_ready), 32'd1);

        for (int w = 0; w < 64; w++) do_req(1'b1, 32'(w * 4), 32'd0, 3'b010, 0, "clear", d, e);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, "sw10", d, e);
        check("sw10_err_lit", 32'(e), 32'd0);
        do_req(1'b0, 32'h11, 32'd0, 3'b000, 0, "lb11", d, e);
        check("lb11_lit", d, 32'hFFFFFFBE);
        do_req(1'b0, 32'h11, 32'd0, 3'b100, 0, "lbu11", d, e);
        check("lbu11_lit", d, 32'h000000BE);
        do_req(1'b0, 32'h12, 32'd0, 3'b001, 0, "lh12", d, e);
        check("lh12_lit", d, 32'hFFFFDEAD);
        do_req(1'b0, 32'h12, 32'd0, 3'b101, 0, "lhu12", d, e);
        check("lhu12_lit", d, 32'h0000DEAD);
        do_req(1'b0, 32'h10, 32'd0, 3'b010, 0, "lw10", d, e);
        check("lw10_lit", d, 32'hDEADBEEF);

        do_req(1'b1, 32'h13, 32'h12, 3'b000, 0, "sb13", d, e);
        do_req(1'b1, 32'h10, 32'hAB77, 3'b001, 0, "sh10", d, e);
        do_req(1'b0, 32'h10, 32'd0, 3'b010, 0, "lw10b", d, e);
        check("lw10b_lit", d, 32'h12ADAB77);

        do_req(1'b0, 32'h21, 32'd0, 3'b001, 0, "f_lh21", d, e);
        check("f_lh21_lit", {d[31:1], e}, 32'd1);
        do_req(1'b1, 32'h22, 32'hFFFFFFFF, 3'b010, 0, "f_sw22", d, e);
        check("f_sw22_lit", {d[31:1], e}, 32'd1);
        do_req(1'b0, 32'(4*DEPTH_WORDS), 32'd0, 3'b010, 0, "f_oor", d, e);
        check("f_oor_lit", {d[31:1], e}, 32'd1);
        do_req(1'b0, 32'h20, 32'd0, 3'b011, 0, "f_m011", d, e);
        check("f_m011_lit", {d[31:1], e}, 32'd1);
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 3'b100, 0, "f_sbu", d, e);
        check("f_sbu_lit", {d[31:1], e}, 32'd1);
        do_req(1'b0, 32'h20, 32'd0, 3'b010, 0, "lw20", d, e);
        check("lw20_lit", d, 32'd0);

        do_req(1'b0, 32'h10, 32'd0, 3'b010, 5, "bp", d, e);
        check("bp_lit", d, 32'h12ADAB77);

        // Abort a store by resetting while it is in flight.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'd0; req_mode = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_vld", 32'(rsp_valid), 32'd0);
        check("abort_rdy", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_quiet", 32'(rsp_valid), 32'd0);
        end
        do_req(1'b0, 32'h10, 32'd0, 3'b010, 0, "abort_lw", d, e);
        check("abort_lw_lit", d, 32'h12ADAB77);

        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'(4*DEPTH_WORDS) + 32'($urandom_range(0, 4095));
            else if (r == 1) a = $urandom;
            else             a = 32'($urandom_range(0, 255));
            do_req(1'($urandom), a, $urandom, 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 2)), "rnd", d, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the processor's load/store port.
- Accepts one request at a time over a valid/ready handshake. Handles RV32I byte, halfword and word accesses, including byte-lane steering and sign/zero extension of load data.
- Returns a response after a programmable latency, so a multi-cycle memory is modelled behind the core's load/store path.
- Holds the data array internally and flags misaligned, out-of-range and illegal-mode accesses.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array. Byte address range is 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2: cycles from the accept edge to rsp_valid. Legal range is 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the value is taken from the low bytes.
- req_mode  in  3  funct3 encoding. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU (BU/HU are legal for loads only).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted.

Behaviour:
- States: INIT, IDLE, BUSY, RESP.
- Reset (asynchronous):
  - Forces INIT, clears the latency counter and all request latches.
  - Output values during reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - The array is NOT cleared.
  - INIT -> IDLE on the first clk edge with rst low.
- req_ready is 1 only in IDLE.
- Acceptance:
  - A request is accepted on an edge where req_valid & req_ready.
  - On accept, latch we/addr/wdata/mode, load cnt = LATENCY-1, and go to BUSY.
- BUSY:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, go to RESP on the next edge. rsp_valid therefore rises exactly LATENCY edges after the accept edge.
- Commit on the edge entering RESP:
  - Evaluate errors first.
  - If there is no error, a store writes only the enabled bytes:
    - SB writes lane addr[1:0] with wdata[7:0].
    - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
    - SW writes all four lanes.
  - If there is no error, a load reads the word at addr[31:2], selects the lane, then extends:
    - B sign-extends bit 7; BU zero-extends.
    - H sign-extends bit 15; HU zero-extends.
    - W returns the full word.
  - rsp_rdata and rsp_err are registered at this edge and held stable throughout RESP.
- Error conditions (rsp_err=1, rsp_rdata=0, no array write):
  - H/HU/SH with addr[0] != 0.
  - W/SW with addr[1:0] != 0.
  - addr[31:2] >= DEPTH_WORDS.
  - req_mode in {011, 110, 111}.
  - Store with mode 100 or 101.
- RESP:
  - rsp_valid=1.
  - Go to IDLE on an edge with rsp_ready=1; otherwise hold all response outputs unchanged.
- Leaving RESP: rsp_valid, rsp_rdata and rsp_err clear on entering IDLE.
- There is no accept in the same cycle as a response retires. Peak throughput is one request per LATENCY+2 cycles.
- Request inputs are ignored outside IDLE. Changing them during BUSY has no effect.
- Ordering and aborts:
  - A load issued after a store to the same word observes the stored data, because the commit precedes the next accept.
  - Reset during BUSY aborts the request: no write occurs and no response is produced.
  - Reset during RESP drops the pending response.
- Latency counter is 4 bits wide. Address arithmetic uses no wrap; out-of-range addresses are errors, not aliases.

Test Plan:
- Reset then basic timing, LATENCY=2:
  - Stimulus: assert then release rst; after req_ready=1, issue SW addr 0x10 wdata 0xDEADBEEF with rsp_ready=1.
  - Required: rsp_valid rises 2 edges after accept; rsp_err=0; req_ready returns to 1 one cycle after the response.
- Byte/half loads with extension:
  - Stimulus: after the store above, issue LB 0x11, LBU 0x11, LH 0x12, LHU 0x12, LW 0x10.
  - Required rsp_rdata: 0xFFFFFFBE, 0x000000BE, 0xFFFFDEAD, 0x0000DEAD, 0xDEADBEEF.
- Partial stores:
  - Stimulus: SB 0x13 wdata 0x12, then SH 0x10 wdata 0xAB77, then LW 0x10.
  - Required: LW returns 0x12ADAB77.
- Faults:
  - Stimulus: LH 0x21, SW 0x22, LW at 4*DEPTH_WORDS, mode 011, store with mode 100.
  - Required: each returns rsp_err=1 and rdata 0; a subsequent LW 0x20 shows the word unchanged.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles during RESP of LW 0x10.
  - Required: rsp_valid and rsp_rdata=0x12ADAB77 are stable throughout; req_ready stays 0; a request presented meanwhile is not accepted.
- Reset mid-operation:
  - Stimulus: accept SW 0x10 wdata 0, assert rst during BUSY, release, then LW 0x10.
  - Required: returns 0x12ADAB77 (store aborted); no spurious rsp_valid before the new request.
